seq_bcd_converter: RTL and testbench

//  Multi-cycle, parametrised binary-to-BCD converter (shift-and-add-3) for the LCD display path.
//  - Converts one input bit per clock under a start/done handshake, replacing the single-cycle unrolled converter.
//  - Feeds the LCD character formatter; scales to any binary width / digit count without combinational depth growth.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/seq_bcd_converter_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/seq_bcd_converter.sv | 117 +++++++++++
 tb/tb_seq_bcd_converter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, FSM state type and sizing helper for the sequential BCD converter
package bcd_pkg;

  localparam int DIGIT_W     = 4;
  localparam int ADD3_THRESH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Bit counter must stay at least one bit wide even for a 1-bit input.
  function automatic int cnt_width(input int bin_width);
    return (bin_width > 1) ? $clog2(bin_width) : 1;
  endfunction

endpackage

// File: rtl/seq_bcd_converter_if.sv
// rtl/seq_bcd_converter_if.sv - start/done handshake and result bus of the BCD converter
interface seq_bcd_converter_if
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 16,
  parameter int NUM_DIGITS = 5
);

  logic                          start;
  logic [BIN_WIDTH-1:0]          binIn;
  logic                          ready;
  logic                          done;
  logic [DIGIT_W*NUM_DIGITS-1:0] bcdOut;
  logic                          overflow;
  logic [NUM_DIGITS-1:0]         blankMask;

  modport master (
    output start, binIn,
    input  ready, done, bcdOut, overflow, blankMask
  );

  modport slave (
    input  start, binIn,
    output ready, done, bcdOut, overflow, blankMask
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction of one BCD digit ahead of the left shift
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i > DIGIT_W'(ADD3_THRESH)) ? d_i + DIGIT_W'(3) : d_i;

endmodule

// File: rtl/seq_bcd_converter.sv
// rtl/seq_bcd_converter.sv - bit-serial shift-and-add-3 binary to BCD converter; BCD_LEADING_ZERO_BLANK_EN enables blankMask
module seq_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  seq_bcd_converter_if.slave  bus
);

  localparam int CNT_W = cnt_width(BIN_WIDTH);
  localparam int BCD_W = DIGIT_W * NUM_DIGITS;

  bcd_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]      digits_q, digits_d, adj;
  logic                  ovf_q, ovf_d;
  logic [BCD_W-1:0]      bcd_q;
  logic                  overflow_q;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  ready, done, accept, last_bit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (digits_q[g*DIGIT_W +: DIGIT_W]),
      .d_o (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign accept   = bus.start & ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q != SHIFT);
    done  = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    if (accept) begin
      shift_d  = bus.binIn;
      digits_d = '0;
      ovf_d    = 1'b0;
      cnt_d    = CNT_W'(BIN_WIDTH - 1);
    end else if (state_q == SHIFT) begin
      // Bit falling out of the top digit means the value needs more digits than we keep.
      digits_d = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
      shift_d  = shift_q << 1;
      ovf_d    = ovf_q | adj[BCD_W-1];
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic upper_zero;
  always_comb begin
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (digits_d[k*DIGIT_W +: DIGIT_W] == '0);
      blank_d[k] = upper_zero & ~ovf_d;
    end
  end
`else
  assign blank_d = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      blank_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      if (last_bit) begin
        bcd_q      <= digits_d;
        overflow_q <= ovf_d;
        blank_q    <= blank_d;
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.bcdOut    = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.blankMask = blank_q;

endmodule

// File: tb/tb_seq_bcd_converter.sv
// tb/tb_seq_bcd_converter.sv - randomized self-checking bench for 16/5 and 8/2 converters against a decimal model
module tb_seq_bcd_converter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  seq_bcd_converter_if #(.BIN_WIDTH(16), .NUM_DIGITS(5)) bus_a ();
  seq_bcd_converter_if #(.BIN_WIDTH(8),  .NUM_DIGITS(2)) bus_b ();

  seq_bcd_converter #(.BIN_WIDTH(16), .NUM_DIGITS(5)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  seq_bcd_converter #(.BIN_WIDTH(8), .NUM_DIGITS(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: value modulo 10^nd, digit by digit, plus leading-zero flags.
  function automatic void model(input int unsigned v, input int nd,
                                output logic [31:0] bcd, output logic [31:0] ovf,
                                output logic [31:0] blk);
    int unsigned lim = 1;
    int unsigned r;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    ovf = {31'd0, (v >= lim)};
    r   = v % lim;
    bcd = '0;
    for (int k = 0; k < nd; k++) begin
      bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    blk = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (ovf == 0) begin
      bit allz = 1'b1;
      for (int k = nd - 1; k >= 1; k--) begin
        if (bcd[4*k +: 4] != 4'd0) allz = 1'b0;
        blk[k] = allz;
      end
    end
`endif
  endfunction

  task automatic do_a(input int unsigned v);
    int lat;
    logic [31:0] eb, eo, ek;
    model(v, 5, eb, eo, ek);
    @(negedge clk);
    chk("a_ready_idle", {31'd0, bus_a.ready}, 32'd1);
    bus_a.start = 1'b1;
    bus_a.binIn = 16'(v);
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.binIn = 16'($urandom);
    chk("a_busy", {31'd0, bus_a.ready}, 32'd0);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_a.done) break;
    end
    chk("a_latency", lat, 16);
    chk("a_bcd", {12'd0, bus_a.bcdOut}, eb);
    chk("a_ovf", {31'd0, bus_a.overflow}, eo);
    chk("a_blank", {27'd0, bus_a.blankMask}, ek);
    @(negedge clk);
    chk("a_done_pulse", {31'd0, bus_a.done}, 32'd0);
    chk("a_bcd_hold", {12'd0, bus_a.bcdOut}, eb);
  endtask

  task automatic do_b(input int unsigned v);
    int lat;
    logic [31:0] eb, eo, ek;
    model(v, 2, eb, eo, ek);
    @(negedge clk);
    bus_b.start = 1'b1;
    bus_b.binIn = 8'(v);
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus_b.done) break;
    end
    chk("b_latency", lat, 8);
    chk("b_bcd", {24'd0, bus_b.bcdOut}, eb);
    chk("b_ovf", {31'd0, bus_b.overflow}, eo);
    chk("b_blank", {30'd0, bus_b.blankMask}, ek);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    int dc [2];
    logic [31:0] db [2];
    logic [31:0] dk;
    logic [31:0] eb, eo, ek;

    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.binIn = '0;
    bus_b.start = 1'b0; bus_b.binIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus_a.ready}, 32'd1);
    chk("rst_done", {31'd0, bus_a.done}, 32'd0);
    chk("rst_bcd", {12'd0, bus_a.bcdOut}, 32'd0);
    chk("rst_ovf", {31'd0, bus_a.overflow}, 32'd0);
    chk("rst_blank", {27'd0, bus_a.blankMask}, 32'd0);
    reset = 1'b0;

    do_a(65535);
    do_a(0);
    do_a(9);
    do_a(10000);
    for (int i = 0; i < 15; i++) do_a($urandom_range(0, 65535));
    for (int i = 0; i < 8; i++) do_a($urandom_range(0, 999));

    // Starts while shifting must be ignored.
    model(1234, 5, eb, eo, ek);
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.binIn = 16'd1234;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    ndone = 0; dk = '0; db[0] = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.done) begin
        ndone++;
        db[0] = {12'd0, bus_a.bcdOut};
        dk    = {27'd0, bus_a.blankMask};
      end
      bus_a.start = (c == 3 || c == 8);
      if (bus_a.start) bus_a.binIn = 16'd9999;
    end
    bus_a.start = 1'b0;
    chk("busy_ndone", ndone, 1);
    chk("busy_bcd", db[0], eb);
    chk("busy_blank", dk, ek);

    // Start held high through DONE chains a second conversion.
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.binIn = 16'd4321;
    @(posedge clk);
    @(negedge clk);
    bus_a.binIn = 16'd7;
    ndone = 0; dc[0] = 0; dc[1] = 0; db[1] = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.done && ndone < 2) begin
        chk("held_ready_done", {31'd0, bus_a.ready}, 32'd1);
        dc[ndone] = c;
        db[ndone] = {12'd0, bus_a.bcdOut};
        ndone++;
        if (ndone == 2) bus_a.start = 1'b0;
      end
    end
    bus_a.start = 1'b0;
    chk("held_ndone", ndone, 2);
    chk("held_lat1", dc[0], 16);
    chk("held_bcd1", db[0], 32'h04321);
    chk("held_lat2", dc[1], 33);
    chk("held_bcd2", db[1], 32'h00007);

    // Reset mid-conversion abandons it.
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.binIn = 16'd5555;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, bus_a.ready}, 32'd1);
    chk("midrst_bcd", {12'd0, bus_a.bcdOut}, 32'd0);
    chk("midrst_done", {31'd0, bus_a.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus_a.done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);
    do_a(100);

    do_b(255);
    do_b(99);
    do_b(0);
    do_b(100);
    for (int i = 0; i < 16; i++) do_b($urandom_range(0, 255));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
